elastic_pipeline: RTL and testbench
===================================

ELASTIC_PIPELINE -- requirements
Module: elastic_pipeline

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits; legal range 1 and up.
REQ-002 The block SHALL have parameter NOF_STAGES, default 4, number of register stages; legal range 1 and up.
REQ-003 The block SHALL have localparam COUNT_WIDTH = $clog2(NOF_STAGES+1), the width of the occupancy count.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port flush_i, input, 1 bit: discard all in-flight data.
REQ-007 The block SHALL have port data_i, input, WIDTH bits: upstream data.
REQ-008 The block SHALL have port valid_i, input, 1 bit: upstream data valid.
REQ-009 The block SHALL have port ready_o, output, 1 bit: block accepts data_i this cycle.
REQ-010 The block SHALL have port data_o, output, WIDTH bits: downstream data, driven from the last stage.
REQ-011 The block SHALL have port valid_o, output, 1 bit: last stage holds valid data.
REQ-012 The block SHALL have port ready_i, input, 1 bit: downstream accepts data_o.
REQ-013 The block SHALL have port count_o, output, COUNT_WIDTH bits: number of occupied stages.

Function
REQ-014 Each stage k (0 = input side, NOF_STAGES-1 = output) SHALL hold one WIDTH-bit data register and one valid bit.
REQ-015 A transfer SHALL occur on an edge where valid and ready are both high: input on valid_i&&ready_o, output on valid_o&&ready_i.
REQ-016 Stage NOF_STAGES-1 SHALL advance when it is empty or ready_i=1; stage k<NOF_STAGES-1 SHALL advance when it is empty or stage k+1 advances (bubble collapse).
REQ-017 ready_o SHALL equal (stage 0 advances) && !flush_i; the ready path is combinational from ready_i.
REQ-018 On an advancing edge, stage k SHALL load the data and valid bit of stage k-1 (stage 0 loads data_i, valid_i&&ready_o); a non-advancing stage SHALL hold both.
REQ-019 Latency SHALL be NOF_STAGES cycles: a word accepted at edge t into an empty pipe with ready_i=1 SHALL appear on data_o with valid_o=1 after edge t+NOF_STAGES-1.
REQ-020 Throughput SHALL be one word per cycle while ready_i=1 and valid_i=1.
REQ-021 While valid_o=1 and ready_i=0, data_o and valid_o SHALL remain stable.
REQ-022 Word order SHALL be preserved; no word SHALL be duplicated or dropped except by flush or reset.
REQ-023 With flush_i=1 at an edge, all valid bits SHALL clear, no input SHALL be accepted, and count_o SHALL read 0 after that edge; any output transfer in that cycle still counts as completed.
REQ-024 count_o SHALL equal the number of set valid bits, ranging 0..NOF_STAGES; when full with ready_i=0, ready_o SHALL be 0.
REQ-025 With NOF_STAGES=1, the block SHALL behave as a single register slice with combinational ready pass-through.

Reset
REQ-026 With rst_i=1 at an edge, all valid bits and data registers SHALL be cleared to 0, giving valid_o=0, data_o=0, count_o=0.
REQ-027 Reset SHALL take priority over flush_i and all transfers; in-flight data SHALL be discarded when reset asserts mid-stream.
REQ-028 During reset ready_o SHALL be 0; after deassertion the block SHALL accept data on the first edge.

Structure
REQ-029 The block SHALL instantiate one sub-module per stage, pipeline_stage (data and valid register, advance logic), in a generate loop.
REQ-030 No shared package is needed; COUNT_WIDTH SHALL stay local to the block.

Verification
REQ-031 WIDTH=8, NOF_STAGES=4, ready_i=1, data_i=0x01..0x08 streamed back-to-back -> valid_o rises 4 cycles after first accept, 0x01..0x08 output on consecutive cycles.
REQ-032 Stream 0x10..0x15 with ready_i=0 -> after 4 accepts ready_o=0 and count_o=4; raise ready_i -> 0x10..0x15 output in order with none lost.
REQ-033 Single word 0xA5, then ready_i toggled 0/1 each cycle -> data_o held at 0xA5 while ready_i=0, output exactly once.
REQ-034 Pipe holding 3 words, flush_i=1 with valid_i=1 data 0x77 -> count_o=0 and valid_o=0 next cycle; 0x77 never output.
REQ-035 rst_i=1 mid-stream with count_o=2 -> next cycle valid_o=0, data_o=0x00, count_o=0; first post-reset word 0x3C emerges after 4 cycles.
REQ-036 Random valid_i/ready_i at 50 % each for 10 000 cycles, NOF_STAGES in {1,4} -> scoreboard sequence matches input and count_o always equals in-flight word count.

Source files
------------

// File: rtl/elastic_pipeline_if.sv
// Stage-to-stage link of the elastic pipeline: forward data/valid and the
// backward advance indication (the receiver loads on this edge).
interface elastic_pipeline_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             advance;

  modport master (output data, output valid, input advance);
  modport slave  (input data, input valid, output advance);
endinterface

// File: rtl/pipeline_stage.sv
// One register slice of the elastic pipeline: holds a word and its valid bit,
// and advances when empty or when the downstream stage advances.
module pipeline_stage #(
  parameter int WIDTH = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  elastic_pipeline_if.slave   up,
  elastic_pipeline_if.master  dn
);
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  // Bubble collapse: an empty stage always takes a new word.
  assign up.advance = !valid_q || dn.advance;
  assign dn.data    = data_q;
  assign dn.valid   = valid_q;

  // NOTE: sequential state uses non-blocking assignments only, so every stage
  // samples its neighbour's pre-edge value and words move one stage per edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (flush_i)         valid_q <= 1'b0;
      else if (up.advance) valid_q <= up.valid;
      // Data may load during a flush; it is harmless because valid is cleared.
      if (up.advance)      data_q  <= up.data;
    end
  end
endmodule

// File: rtl/elastic_pipeline.sv
// Elastic valid/ready pipeline of NOF_STAGES register slices with flush and
// an occupancy count; the ready path is combinational from ready_i.
module elastic_pipeline #(
  parameter  int WIDTH       = 8,
  parameter  int NOF_STAGES  = 4,
  localparam int COUNT_WIDTH = $clog2(NOF_STAGES + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  output logic [WIDTH-1:0]       data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic [COUNT_WIDTH-1:0] count_o
);
  // link[k] feeds stage k; link[NOF_STAGES] is the downstream port.
  elastic_pipeline_if #(.WIDTH(WIDTH)) link [NOF_STAGES+1] ();

  logic [NOF_STAGES-1:0] valid_vec;

  assign ready_o                   = link[0].advance && !flush_i && !rst_i;
  assign link[0].data              = data_i;
  assign link[0].valid             = valid_i && ready_o;
  assign link[NOF_STAGES].advance  = ready_i;
  assign data_o                    = link[NOF_STAGES].data;
  assign valid_o                   = link[NOF_STAGES].valid;

  for (genvar k = 0; k < NOF_STAGES; k++) begin : g_stage
    pipeline_stage #(.WIDTH(WIDTH)) u_stage (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .flush_i (flush_i),
      .up      (link[k]),
      .dn      (link[k+1])
    );
    assign valid_vec[k] = link[k+1].valid;
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < NOF_STAGES; i++) begin
      count_o = count_o + COUNT_WIDTH'(valid_vec[i]);
    end
  end
endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed and random checks of elastic_pipeline (4-stage and 1-stage builds).
module tb_elastic_pipeline;
  logic       clk = 1'b0;
  logic       rst;
  logic       flush;

  // Shared upstream stimulus; advance carries the downstream ready_i.
  elastic_pipeline_if #(.WIDTH(8)) stim_if ();

  logic       ready4, valid4, ready1, valid1;
  logic [7:0] data4, data1;
  logic [2:0] count4;
  logic [0:0] count1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  elastic_pipeline #(.WIDTH(8), .NOF_STAGES(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .data_i(stim_if.data), .valid_i(stim_if.valid), .ready_o(ready4),
    .data_o(data4), .valid_o(valid4), .ready_i(stim_if.advance), .count_o(count4)
  );

  elastic_pipeline #(.WIDTH(8), .NOF_STAGES(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .data_i(stim_if.data), .valid_i(stim_if.valid), .ready_o(ready1),
    .data_o(data1), .valid_o(valid1), .ready_i(stim_if.advance), .count_o(count1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    stim_if.valid   = v;
    stim_if.data    = d;
    stim_if.advance = r;
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 8'h00, 1'b1);
    repeat (6) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0;
    drive(1'b1, 8'hFF, 1'b1);
    checks++;
    if (ready4 !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b exp=0", ready4); end
    tick(); tick();
    checks++;
    if (valid4 !== 1'b0 || data4 !== 8'h00 || count4 !== 3'd0) begin
      errors++; $display("FAIL rst_state got v=%b d=%h c=%0d exp v=0 d=00 c=0", valid4, data4, count4);
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (ready4 !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b exp=1", ready4); end
  endtask

  // 0x01..0x08 back-to-back; word n appears in cycle n+3.
  task automatic test_stream();
    for (int c = 0; c < 14; c++) begin
      int acc, outs;
      drive(c < 8, 8'(c + 1), 1'b1);
      acc  = (c < 8) ? c : 8;
      outs = (c < 4) ? 0 : ((c - 4 > 8) ? 8 : c - 4);
      checks++;
      if (valid4 !== (c >= 4 && c < 12)) begin
        errors++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, valid4, (c >= 4 && c < 12));
      end
      if (c >= 4 && c < 12) begin
        checks++;
        if (data4 !== 8'(c - 3)) begin errors++; $display("FAIL stream_data c=%0d got=%h exp=%h", c, data4, 8'(c - 3)); end
      end
      checks++;
      if (count4 !== 3'(acc - outs)) begin
        errors++; $display("FAIL stream_count c=%0d got=%0d exp=%0d", c, count4, acc - outs);
      end
      tick();
    end
  endtask

  // Fill with ready_i=0, then drain and confirm order 0x10..0x15.
  task automatic test_backpressure();
    int sent = 0, got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      logic r;
      r = (c >= 6);
      drive(sent < 6, 8'(8'h10 + sent), r);
      if (c == 5) begin
        checks++;
        if (ready4 !== 1'b0 || count4 !== 3'd4) begin
          errors++; $display("FAIL bp_full got ready=%b count=%0d exp ready=0 count=4", ready4, count4);
        end
        checks++;
        if (valid4 !== 1'b1 || data4 !== 8'h10) begin
          errors++; $display("FAIL bp_head got v=%b d=%h exp v=1 d=10", valid4, data4);
        end
      end
      if (valid4 && r) begin
        checks++;
        if (data4 !== 8'(8'h10 + got)) begin
          errors++; $display("FAIL bp_order got=%h exp=%h", data4, 8'(8'h10 + got));
        end
        got++;
      end
      if (sent < 6 && ready4) sent++;
      tick();
    end
    checks++;
    if (got !== 6) begin errors++; $display("FAIL bp_total got=%0d exp=6", got); end
  endtask

  // 0xA5 alone, ready_i toggling; held while stalled, delivered exactly once.
  task automatic test_stall();
    int outs = 0;
    for (int c = 0; c < 12; c++) begin
      logic r;
      r = c[0];
      drive(c == 0, 8'hA5, r);
      if (valid4) begin
        checks++;
        if (data4 !== 8'hA5) begin errors++; $display("FAIL stall_data c=%0d got=%h exp=a5", c, data4); end
        if (r) outs++;
      end
      if (c == 4) begin
        checks++;
        if (valid4 !== 1'b1) begin errors++; $display("FAIL stall_arrive got=%b exp=1", valid4); end
      end
      tick();
    end
    checks++;
    if (outs !== 1) begin errors++; $display("FAIL stall_once got=%0d exp=1", outs); end
  endtask

  task automatic test_flush();
    int outs = 0;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 8'(8'h31 + c), 1'b0);
      tick();
    end
    checks++;
    if (count4 !== 3'd3) begin errors++; $display("FAIL flush_pre_count got=%0d exp=3", count4); end
    flush = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    checks++;
    if (ready4 !== 1'b0) begin errors++; $display("FAIL flush_ready got=%b exp=0", ready4); end
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    checks++;
    if (count4 !== 3'd0 || valid4 !== 1'b0) begin
      errors++; $display("FAIL flush_clear got c=%0d v=%b exp c=0 v=0", count4, valid4);
    end
    for (int c = 0; c < 8; c++) begin
      if (valid4) outs++;
      tick();
    end
    checks++;
    if (outs !== 0) begin errors++; $display("FAIL flush_leak got=%0d outputs exp=0", outs); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h41, 1'b0); tick();
    drive(1'b1, 8'h42, 1'b0); tick();
    checks++;
    if (count4 !== 3'd2) begin errors++; $display("FAIL rmid_pre_count got=%0d exp=2", count4); end
    rst = 1'b1;
    drive(1'b1, 8'h55, 1'b1);
    checks++;
    if (ready4 !== 1'b0) begin errors++; $display("FAIL rmid_ready got=%b exp=0", ready4); end
    tick();
    rst = 1'b0;
    drive(1'b1, 8'h3C, 1'b1);
    checks++;
    if (valid4 !== 1'b0 || data4 !== 8'h00 || count4 !== 3'd0) begin
      errors++; $display("FAIL rmid_state got v=%b d=%h c=%0d exp v=0 d=00 c=0", valid4, data4, count4);
    end
    checks++;
    if (ready4 !== 1'b1) begin errors++; $display("FAIL rmid_accept got=%b exp=1", ready4); end
    tick();
    drive(1'b0, 8'h00, 1'b1);
    tick(); tick();
    checks++;
    if (valid4 !== 1'b0) begin errors++; $display("FAIL rmid_early got=%b exp=0", valid4); end
    tick();
    checks++;
    if (valid4 !== 1'b1 || data4 !== 8'h3C) begin
      errors++; $display("FAIL rmid_first got v=%b d=%h exp v=1 d=3c", valid4, data4);
    end
    drain();
  endtask

  // Random traffic on both builds with queue scoreboards.
  task automatic test_random();
    logic [7:0] q4[$];
    logic [7:0] q1[$];
    rst = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic v, r;
      logic [7:0] d, e;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      drive(v, d, r);
      checks++;
      if (count4 !== 3'(q4.size())) begin
        errors++; $display("FAIL rnd4_count c=%0d got=%0d exp=%0d", c, count4, q4.size());
      end
      checks++;
      if (count1 !== 1'(q1.size())) begin
        errors++; $display("FAIL rnd1_count c=%0d got=%0d exp=%0d", c, count1, q1.size());
      end
      if (valid4 && r) begin
        e = (q4.size() > 0) ? q4.pop_front() : 8'hxx;
        checks++;
        if (data4 !== e) begin errors++; $display("FAIL rnd4_data c=%0d got=%h exp=%h", c, data4, e); end
      end
      if (valid1 && r) begin
        e = (q1.size() > 0) ? q1.pop_front() : 8'hxx;
        checks++;
        if (data1 !== e) begin errors++; $display("FAIL rnd1_data c=%0d got=%h exp=%h", c, data1, e); end
      end
      if (v && ready4) q4.push_back(d);
      if (v && ready1) q1.push_back(d);
      tick();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    stim_if.valid = 1'b0; stim_if.data = 8'h00; stim_if.advance = 1'b0;
    tick();
    test_reset();
    test_stream();
    drain();
    test_backpressure();
    drain();
    test_stall();
    drain();
    test_flush();
    drain();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
